mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single byte-wide external RAM port between two requesters: instruction fetch (IF, 4-byte reads only) and the MEM stage (1/2/4-byte loads and stores).
- Serialises each word access into byte beats and assembles or disassembles little-endian words.
- Raises stall requests so the pipeline control holds IF/ID/EX while an access is outstanding.

Parameters:
- ADDR_W, 17, width of the RAM byte address driven on ram_a.
- RD_LAT, 1, RAM read latency in cycles. A byte is valid on ram_din RD_LAT cycles after its address is driven.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset. Clock and reset are fixed as one clock, asynchronous, active-low.
- if_req  in  1  IF requests a 4-byte read.
- if_addr  in  32  IF byte address; bits above ADDR_W are ignored.
- if_done  out  1  one-cycle pulse; if_data is valid.
- if_data  out  32  fetched instruction word.
- mem_req  in  1  MEM-stage access request.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  byte count minus 1; legal values 0, 1, 3.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  store data, low bytes used.
- mem_done  out  1  one-cycle pulse; the access is complete.
- mem_rdata  out  32  load data, zero-extended. Sign-extension happens in the MEM stage.
- ram_a  out  ADDR_W  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_wr  out  1  RAM write strobe.
- ram_din  in  8  RAM read byte.
- stall_if  out  1  hold PC and IF/ID.
- stall_mem  out  1  hold EX/MEM and all earlier stages.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; byte counters cleared; assembly register cleared.
- States:
  - IDLE: sample requests each cycle.
  - RD: issue read address beats, capture returning bytes.
  - WR: drive one write byte per cycle.
  - DONE: pulse the done output, return to IDLE.
- Arbitration in IDLE:
  - mem_req has strict priority over if_req.
  - The winner's address, length and write data are latched at the accepting edge.
  - Requests arriving while not IDLE are ignored. Requesters hold req high until their done pulse.
- Read of N bytes (IF always N=4):
  - Address byte k (base+k) is driven on ram_a on cycle k after acceptance, k = 0..N-1, with ram_wr=0.
  - ram_din is captured into byte lane k on cycle k+RD_LAT.
  - The done pulse occurs on the cycle after the last capture, with data stable that cycle.
  - With RD_LAT=1: done is asserted N+1 cycles after the accepting edge; a 4-byte fetch occupies the port for 5 cycles plus 1 DONE cycle.
- Write of N bytes:
  - ram_a = base+k, ram_dout = mem_wdata[8k+7:8k], ram_wr=1, on cycle k.
  - mem_done pulses on cycle N.
  - ram_wr is 0 in every other state.
- Address arithmetic: base+k is computed modulo 2^ADDR_W. Address 0x1FFFF+1 wraps to 0x00000.
- Stalls:
  - stall_mem = mem_req & ~mem_done (combinational), so the pipeline releases in the done cycle.
  - stall_if = (if_req & ~if_done) | stall_mem.
- Back-to-back: mem_req and if_req both pending at DONE → DONE → IDLE → mem served first. IF is never starved because MEM requests are bounded by pipeline flow.
- Illegal mem_len=2 is treated as 4 bytes.
- Reset asserted mid-transaction: the transaction is dropped immediately, ram_wr is forced 0, and no done pulse is issued.

Optional Feature:
- MEM_ARB_IF_ABORT_EN adds an input if_flush (1 bit), driven by branch resolution in EX.
- With the macro: if_flush high while an IF read is in RD aborts it at the next edge.
  - Return to IDLE.
  - Suppress if_done.
  - Discard captured bytes.
  - A pending mem_req may be accepted in the following cycle.
- Without the macro: the port does not exist, and IF reads always complete. The pipeline discards the stale instruction.

Decomposition:
- Shared package/define file holds:
  - state encodings ARB_IDLE, ARB_RD, ARB_WR, ARB_DONE;
  - length codes LEN_B=0, LEN_H=1, LEN_W=3;
  - RAM_ADDR_W.
- One natural sub-module, byte_assembler: a 4-lane byte shift/capture register with lane index and clear. Used for read assembly; its lane selects are reused as a mux for write disassembly.

Test Plan:
- IF fetch at 0x00010, RAM holds bytes 13 00 00 00 at 0x10..0x13:
  - ram_a = 0x10, 0x11, 0x12, 0x13 on consecutive cycles;
  - if_done pulses 5 cycles after acceptance with if_data=0x00000013;
  - stall_if is high until the done cycle.
- Store word 0xDEADBEEF at 0x00100:
  - ram_wr high for 4 cycles;
  - ram_dout = EF, BE, AD, DE at 0x100..0x103;
  - mem_done pulses on cycle 4.
- Load byte at 0x00005 holding 0x80 → mem_rdata=0x00000080 with mem_done 2 cycles after acceptance.
- if_req and mem_req raised in the same cycle:
  - MEM load completes first, then IF;
  - if_done occurs only after mem_done, plus a DONE and an IDLE cycle.
- Halfword load at 0x1FFFF:
  - ram_a = 0x1FFFF then 0x00000;
  - mem_rdata = {16'h0, byte@0, byte@1FFFF}.
- Reset pulled low two cycles into a word store:
  - ram_wr drops to 0 asynchronously, no mem_done is issued, state is IDLE after release.
  - With MEM_ARB_IF_ABORT_EN, if_flush in cycle 2 of a fetch → no if_done.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Default width of the external RAM byte address
    localparam int RAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    // MEM-stage length codes (byte count minus one)
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    // Index of the last byte lane for a length code. The illegal
    // code 2 falls into the default and is served as a full word.
    function automatic logic [1:0] last_lane(input logic [1:0] len);
        case (len)
            LEN_B:   last_lane = 2'd0;
            LEN_H:   last_lane = 2'd1;
            default: last_lane = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// 4-lane byte register: captures bytes into a lane for read assembly and
// muxes one lane out for write disassembly. Latency: one edge per capture.
// Backpressure: none; the controller drives every strobe.
//
// Ports: clk/rst (async active-low), load/load_val (whole-word load),
// clr (zero all lanes), cap/cap_lane/cap_byte (write one lane),
// sel_lane/sel_byte (lane read mux), word_nxt (value after this edge).
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        clr,
    input  logic        cap,
    input  logic [1:0]  cap_lane,
    input  logic [7:0]  cap_byte,
    input  logic [1:0]  sel_lane,
    output logic [31:0] word_nxt,
    output logic [7:0]  sel_byte
);

    logic [31:0] word;

    // word_nxt is exported so the controller can register the finished
    // word on the same edge that captures the final byte.
    always_comb begin
        word_nxt = word;
        if (load) begin
            word_nxt = load_val;
        end else if (clr) begin
            word_nxt = '0;
        end else if (cap) begin
            word_nxt[{cap_lane, 3'b000} +: 8] = cap_byte;
        end
    end

    assign sel_byte = word[{sel_lane, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
        end else begin
            word <= word_nxt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between IF (word reads) and MEM (1/2/4 byte loads/stores).
// Latency: read of N bytes done N+RD_LAT cycles after accept; write of N bytes done N cycles after.
// Backpressure: requesters hold req until done; stall_if/stall_mem hold the pipeline meanwhile.
//
// Ports: clk, rst (async active-low); IF side if_req/if_addr -> if_done/if_data;
// MEM side mem_req/mem_we/mem_len/mem_addr/mem_wdata -> mem_done/mem_rdata;
// RAM side ram_a/ram_dout/ram_wr out, ram_din in; stall_if/stall_mem to pipeline control.
// Optional: define MEM_ARB_IF_ABORT_EN to add if_flush, which aborts an in-flight IF read.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
`ifdef MEM_ARB_IF_ABORT_EN
    input  logic              if_flush,
`endif
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stall_if,
    output logic              stall_mem
);

    // Beat counter must reach last lane + RD_LAT
    localparam int CNT_W = $clog2(RD_LAT + 5);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RD_LAT);

    arb_state_t        state;
    logic              serve_if;   // current access belongs to IF
    logic [ADDR_W-1:0] base;
    logic [1:0]        last;       // last byte lane of the current access
    logic [CNT_W-1:0]  cyc;        // cycles since acceptance

    logic [ADDR_W-1:0] addr_nxt;
    logic [CNT_W-1:0]  last_c;
    logic              acc_mem;
    logic              acc_if;
    logic              flush_abort;
    logic              asm_load;
    logic              asm_clr;
    logic              asm_cap;
    logic [1:0]        asm_cap_lane;
    logic [1:0]        asm_sel_lane;
    logic [31:0]       asm_word_nxt;
    logic [7:0]        asm_sel_byte;

    // Upper address bits are outside the RAM and deliberately dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    // Address of the next beat; wraps modulo 2^ADDR_W by truncation
    assign addr_nxt = base + ADDR_W'(cyc) + ADDR_W'(1);
    assign last_c   = CNT_W'(last);

    assign acc_mem = (state == ARB_IDLE) && mem_req;
    assign acc_if  = (state == ARB_IDLE) && !mem_req && if_req;

`ifdef MEM_ARB_IF_ABORT_EN
    assign flush_abort = (state == ARB_RD) && serve_if && if_flush;
`else
    assign flush_abort = 1'b0;
`endif

    // Stores preload the word so the lane mux can feed ram_dout; reads
    // start from zero so unused upper lanes give zero-extension.
    assign asm_load     = acc_mem && mem_we;
    assign asm_clr      = (acc_mem && !mem_we) || acc_if || flush_abort;
    assign asm_cap      = (state == ARB_RD) && (cyc >= LAT_C);
    assign asm_cap_lane = 2'(cyc - LAT_C);
    assign asm_sel_lane = 2'(cyc + CNT_W'(1));

    byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .load     (asm_load),
        .load_val (mem_wdata),
        .clr      (asm_clr),
        .cap      (asm_cap),
        .cap_lane (asm_cap_lane),
        .cap_byte (ram_din),
        .sel_lane (asm_sel_lane),
        .word_nxt (asm_word_nxt),
        .sel_byte (asm_sel_byte)
    );

    // Released in the done cycle so the pipeline advances with the data
    assign stall_mem = mem_req && !mem_done;
    assign stall_if  = (if_req && !if_done) || stall_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            serve_if  <= 1'b0;
            base      <= '0;
            last      <= '0;
            cyc       <= '0;
            ram_a     <= '0;
            ram_dout  <= '0;
            ram_wr    <= 1'b0;
            if_done   <= 1'b0;
            if_data   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // MEM has strict priority; IF cannot starve because
                    // MEM traffic is bounded by pipeline flow.
                    if (mem_req) begin
                        serve_if <= 1'b0;
                        base     <= mem_addr[ADDR_W-1:0];
                        ram_a    <= mem_addr[ADDR_W-1:0];
                        last     <= last_lane(mem_len);
                        cyc      <= '0;
                        if (mem_we) begin
                            state    <= ARB_WR;
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                        end else begin
                            state <= ARB_RD;
                        end
                    end else if (if_req) begin
                        serve_if <= 1'b1;
                        base     <= if_addr[ADDR_W-1:0];
                        ram_a    <= if_addr[ADDR_W-1:0];
                        last     <= LEN_W;
                        cyc      <= '0;
                        state    <= ARB_RD;
                    end
                end

                ARB_RD: begin
                    if (flush_abort) begin
                        state <= ARB_IDLE;
                    end else begin
                        if (cyc < last_c) begin
                            ram_a <= addr_nxt;
                        end
                        // Final byte lands in the assembler at this edge;
                        // register the completed word alongside it.
                        if (cyc == last_c + LAT_C) begin
                            state <= ARB_DONE;
                            if (serve_if) begin
                                if_done <= 1'b1;
                                if_data <= asm_word_nxt;
                            end else begin
                                mem_done  <= 1'b1;
                                mem_rdata <= asm_word_nxt;
                            end
                        end
                        cyc <= cyc + CNT_W'(1);
                    end
                end

                ARB_WR: begin
                    if (cyc == last_c) begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= ARB_DONE;
                    end else begin
                        ram_a    <= addr_nxt;
                        ram_dout <= asm_sel_byte;
                        cyc      <= cyc + CNT_W'(1);
                    end
                end

                ARB_DONE: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    state    <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
